// File: rtl/ras_ckpt_pkg.sv
// Shared frontend/backend types for the checkpointed return address stack.
// Optional top-entry repair is enabled by defining RAS_CKPT_TOP_REPAIR_EN.
package ras_ckpt_pkg;

    localparam int unsigned RAS_DEPTH      = 8;
    localparam int unsigned RAS_XLEN       = 32;
    localparam int unsigned COB_DEPTH      = 16;
    localparam int unsigned COB_ADDR_WIDTH = $clog2(COB_DEPTH);

    // Checkpoint payload for the default configuration.
    typedef struct packed {
        logic [$clog2(RAS_DEPTH)-1:0] tos;
        logic [$clog2(RAS_DEPTH):0]   count;
`ifdef RAS_CKPT_TOP_REPAIR_EN
        logic [RAS_XLEN-1:0]          top;
`endif
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_file.sv
// Per-tag checkpoint register file: one write port, one combinational read port.
module ras_ckpt_file
    import ras_ckpt_pkg::*;
#(
    parameter int unsigned NUM_TAGS = COB_DEPTH,
    parameter type         entry_t  = ras_ckpt_t
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_TAGS)-1:0] wr_tag,
    input  entry_t                      wr_data,
    input  logic [$clog2(NUM_TAGS)-1:0] rd_tag,
    output entry_t                      rd_data
);

    entry_t slots [NUM_TAGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                slots[i] <= '0;
            end
        end else if (wr_en) begin
            slots[wr_tag] <= wr_data;
        end
    end

    assign rd_data = slots[rd_tag];

endmodule

// File: rtl/ras_ckpt.sv
// Return address stack with per-branch-tag checkpoint and recovery.
// Define RAS_CKPT_TOP_REPAIR_EN to also checkpoint and repair the top entry.
module ras_ckpt
    import ras_ckpt_pkg::*;
#(
    parameter int unsigned DEPTH    = RAS_DEPTH,
    parameter int unsigned NUM_TAGS = COB_DEPTH,
    parameter int unsigned XLEN     = RAS_XLEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_en,
    input  logic [XLEN-1:0]             push_addr,
    input  logic                        pop_en,
    output logic [XLEN-1:0]             pop_addr,
    output logic                        pop_valid,
    input  logic                        ckpt_en,
    input  logic [$clog2(NUM_TAGS)-1:0] ckpt_tag,
    input  logic                        recover_en,
    input  logic [$clog2(NUM_TAGS)-1:0] recover_tag,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PTR_W-1:0] tos;
        logic [CNT_W-1:0] count;
`ifdef RAS_CKPT_TOP_REPAIR_EN
        logic [XLEN-1:0]  top;
`endif
    } ckpt_t;

    logic [XLEN-1:0]  stack [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W-1:0] tos_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;
    logic             ckpt_we;
    ckpt_t            ckpt_wdata;
    ckpt_t            ckpt_rdata;

    assign empty     = (count == '0);
    assign pop_addr  = stack[tos];
    assign pop_valid = pop_en & ~empty;

    // Next pointer/count and stack write: flush > recover > push/pop.
    always_comb begin
        tos_nxt   = tos;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = tos;
        wr_data   = push_addr;
        if (flush) begin
            tos_nxt   = '0;
            count_nxt = '0;
        end else if (recover_en) begin
            tos_nxt   = ckpt_rdata.tos;
            count_nxt = ckpt_rdata.count;
`ifdef RAS_CKPT_TOP_REPAIR_EN
            wr_en     = 1'b1;
            wr_idx    = ckpt_rdata.tos;
            wr_data   = ckpt_rdata.top;
`endif
        end else if (push_en && pop_en && !empty) begin
            wr_en = 1'b1;
        end else if (push_en) begin
            tos_nxt   = tos + PTR_W'(1);
            wr_en     = 1'b1;
            wr_idx    = tos + PTR_W'(1);
            count_nxt = (count == CNT_W'(DEPTH)) ? count : count + CNT_W'(1);
        end else if (pop_en && !empty) begin
            tos_nxt   = tos - PTR_W'(1);
            count_nxt = count - CNT_W'(1);
        end
    end

    // Checkpoint captures the post-operation state of this cycle.
    always_comb begin
        ckpt_wdata       = '0;
        ckpt_wdata.tos   = tos_nxt;
        ckpt_wdata.count = count_nxt;
`ifdef RAS_CKPT_TOP_REPAIR_EN
        ckpt_wdata.top   = push_en ? push_addr : stack[tos_nxt];
`endif
    end

    assign ckpt_we = ckpt_en & ~rst & ~flush & ~recover_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
            tos   <= '0;
            count <= '0;
        end else begin
            tos   <= tos_nxt;
            count <= count_nxt;
            if (wr_en) begin
                stack[wr_idx] <= wr_data;
            end
        end
    end

    ras_ckpt_file #(
        .NUM_TAGS (NUM_TAGS),
        .entry_t  (ckpt_t)
    ) u_ckpt_file (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ckpt_we),
        .wr_tag  (ckpt_tag),
        .wr_data (ckpt_wdata),
        .rd_tag  (recover_tag),
        .rd_data (ckpt_rdata)
    );

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed self-checking bench for ras_ckpt (default DEPTH=8, NUM_TAGS=16, XLEN=32).
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_en;
    logic [31:0] push_addr;
    logic        pop_en;
    logic [31:0] pop_addr;
    logic        pop_valid;
    logic        ckpt_en;
    logic [3:0]  ckpt_tag;
    logic        recover_en;
    logic [3:0]  recover_tag;
    logic        flush;
    logic [3:0]  count;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ras_ckpt dut (
        .clk         (clk),
        .rst         (rst),
        .push_en     (push_en),
        .push_addr   (push_addr),
        .pop_en      (pop_en),
        .pop_addr    (pop_addr),
        .pop_valid   (pop_valid),
        .ckpt_en     (ckpt_en),
        .ckpt_tag    (ckpt_tag),
        .recover_en  (recover_en),
        .recover_tag (recover_tag),
        .flush       (flush),
        .count       (count),
        .empty       (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle before the next rising edge.
    task automatic cyc(input bit pu, input logic [31:0] pa, input bit po,
                       input bit ck, input logic [3:0] ct,
                       input bit rc, input logic [3:0] rt, input bit fl);
        @(negedge clk);
        push_en     = pu;
        push_addr   = pa;
        pop_en      = po;
        ckpt_en     = ck;
        ckpt_tag    = ct;
        recover_en  = rc;
        recover_tag = rt;
        flush       = fl;
        #1;
    endtask

    task automatic idle();
        cyc(0, 32'h0, 0, 0, 4'd0, 0, 4'd0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        cyc(0, 32'h0, 1, 0, 4'd0, 0, 4'd0, 0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_pop_addr", pop_addr, 32'h0);
        check("reset_pop_valid", 32'(pop_valid), 32'd0);

        // Basic push/pop
        cyc(1, 32'h100, 0, 0, 4'd0, 0, 4'd0, 0);
        cyc(1, 32'h200, 0, 0, 4'd0, 0, 4'd0, 0);
        cyc(1, 32'h300, 0, 0, 4'd0, 0, 4'd0, 0);
        cyc(0, 32'h0, 1, 0, 4'd0, 0, 4'd0, 0);
        check("basic_count", 32'(count), 32'd3);
        check("basic_pop_addr", pop_addr, 32'h300);
        check("basic_pop_valid", 32'(pop_valid), 32'd1);
        idle();
        check("basic_after_pop", pop_addr, 32'h200);
        check("basic_after_count", 32'(count), 32'd2);

        // Overflow wrap then drain to empty
        cyc(0, 32'h0, 0, 0, 4'd0, 0, 4'd0, 1);
        for (int i = 1; i <= 9; i++) cyc(1, 32'(i * 16), 0, 0, 4'd0, 0, 4'd0, 0);
        idle();
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_top", pop_addr, 32'h90);
        for (int i = 9; i >= 2; i--) begin
            cyc(0, 32'h0, 1, 0, 4'd0, 0, 4'd0, 0);
            check("drain_pop_addr", pop_addr, 32'(i * 16));
            check("drain_pop_valid", 32'(pop_valid), 32'd1);
        end
        cyc(0, 32'h0, 1, 0, 4'd0, 0, 4'd0, 0);
        check("underflow_pop_valid", 32'(pop_valid), 32'd0);
        idle();
        check("underflow_count", 32'(count), 32'd0);
        check("underflow_empty", 32'(empty), 32'd1);

        // Checkpoint at tag 3, wrong-path ops, recover
        cyc(0, 32'h0, 0, 0, 4'd0, 0, 4'd0, 1);
        cyc(1, 32'hA0, 0, 1, 4'd3, 0, 4'd0, 0);
        cyc(0, 32'h0, 1, 0, 4'd0, 0, 4'd0, 0);
        cyc(0, 32'h0, 1, 0, 4'd0, 0, 4'd0, 0);
        check("wp_pop_empty_valid", 32'(pop_valid), 32'd0);
        cyc(1, 32'hDEAD, 0, 0, 4'd0, 0, 4'd0, 0);
        cyc(0, 32'h0, 0, 0, 4'd0, 1, 4'd3, 0);
        idle();
        check("recover_count", 32'(count), 32'd1);
`ifdef RAS_CKPT_TOP_REPAIR_EN
        check("recover_top", pop_addr, 32'hA0);
`else
        check("recover_top", pop_addr, 32'hDEAD);
`endif

        // Simultaneous push and pop replaces the top
        cyc(0, 32'h0, 0, 0, 4'd0, 0, 4'd0, 1);
        cyc(1, 32'h30, 0, 0, 4'd0, 0, 4'd0, 0);
        cyc(1, 32'h40, 0, 0, 4'd0, 0, 4'd0, 0);
        cyc(1, 32'h50, 1, 0, 4'd0, 0, 4'd0, 0);
        check("copop_pop_addr", pop_addr, 32'h40);
        check("copop_pop_valid", 32'(pop_valid), 32'd1);
        idle();
        check("copop_top", pop_addr, 32'h50);
        check("copop_count", 32'(count), 32'd2);

        // Recover wins over push and checkpoint in the same cycle
        cyc(1, 32'h77, 0, 1, 4'd5, 1, 4'd3, 0);
        idle();
        check("rec_prio_count", 32'(count), 32'd1);
`ifdef RAS_CKPT_TOP_REPAIR_EN
        check("rec_prio_top", pop_addr, 32'hA0);
`else
        check("rec_prio_top", pop_addr, 32'h30);
`endif
        cyc(0, 32'h0, 0, 0, 4'd0, 1, 4'd5, 0);
        idle();
        check("unwritten_tag_count", 32'(count), 32'd0);

        // Flush wins over recover
        cyc(1, 32'h11, 0, 0, 4'd0, 0, 4'd0, 0);
        cyc(0, 32'h0, 0, 0, 4'd0, 1, 4'd3, 1);
        idle();
        check("flush_prio_count", 32'(count), 32'd0);

        // Synchronous reset mid-sequence clears stack and checkpoints
        for (int i = 1; i <= 5; i++) cyc(1, 32'(32'h1000 + i), 0, 0, 4'(i), 0, 4'd0, 0);
        idle();
        check("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        idle();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_pop_addr", pop_addr, 32'h0);
        cyc(0, 32'h0, 0, 0, 4'd0, 1, 4'd3, 0);
        idle();
        check("rst_recover_count", 32'(count), 32'd0);
        check("rst_recover_top", pop_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
- Parametrised successor to the fetch-stage 8-entry return address stack (RAS).
- The current RAS is discarded on every flush. This block instead checkpoints RAS state per branch tag (COB index) when a control-flow instruction is allocated.
- On a branch-resolution kill it restores the state of that tag, so correct-path return prediction survives mispredicts.
- Sits in the frontend beside the BTB and predictor. Driven by predecode (push/pop), COB allocation (checkpoint) and the branch resolution bus (recover).

Parameters:
- DEPTH, 8, number of stack entries; power of two, >= 2.
- NUM_TAGS, COB_DEPTH, number of checkpoint slots, indexed by branch tag.
- XLEN, 32, return address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_en  in  1  call predecoded this cycle (JAL/JALR with rd in {x1,x5})
- push_addr  in  XLEN  return address to push (pc+4)
- pop_en  in  1  return predecoded this cycle
- pop_addr  out  XLEN  current top-of-stack entry (combinational)
- pop_valid  out  1  pop_en & ~empty
- ckpt_en  in  1  COB entry allocated for a control-flow instruction this cycle
- ckpt_tag  in  $clog2(NUM_TAGS)  COB index being allocated
- recover_en  in  1  branch-resolution broadcast & kill
- recover_tag  in  $clog2(NUM_TAGS)  tag of the mispredicted branch
- flush  in  1  full frontend flush not tied to a tag (exception/reset path)
- count  out  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage: circular array stack[DEPTH]; tos pointer of log2(DEPTH) bits; count saturating at DEPTH. tos wraps modulo DEPTH. Overflow silently overwrites the oldest entry.
- Reset (sync):
  - all stack entries 0, tos 0, count 0, all checkpoint slots 0.
  - Result: empty=1, pop_valid=0, pop_addr=0.
- pop_addr = stack[tos] at all times, combinational, zero latency.
- Priority each cycle: rst > flush > recover_en > push/pop. ckpt_en is ignored in any cycle where rst, flush or recover_en is high.
- flush: tos<=0, count<=0. Entries and checkpoints are not cleared.
- Push only:
  - tos<=tos+1, stack[tos+1]<=push_addr.
  - count<=min(count+1, DEPTH).
- Pop only:
  - count!=0: tos<=tos-1, count<=count-1.
  - count==0: no state change, pop_valid=0.
- Push and pop together (coroutine JALR):
  - pop_addr returns the old top.
  - stack[tos]<=push_addr; tos and count unchanged.
  - If count==0: behaves as push only, pop_valid=0.
- Checkpoint: slot[ckpt_tag] <= {tos, count, top} of the state *after* this cycle's push/pop. top is push_addr if push_en, else the entry at the post-op tos. The checkpointed instruction's own call/return is therefore preserved on recovery.
- Recover (recover_en):
  - tos<=slot.tos, count<=slot.count, stack[slot.tos]<=slot.top.
  - push_en/pop_en that cycle are ignored, since they belong to the wrong path.
  - Visible from the next cycle.
- A checkpoint written at tag T in cycle N is readable by recover at tag T from cycle N+1.
- Recovering a never-written tag restores its reset/previous contents. This is not an error.
- All outputs except pop_addr/pop_valid/empty are registered state.

Optional Feature:
- Macro RAS_CKPT_TOP_REPAIR_EN.
- Defined: checkpoints hold the top entry and recovery rewrites stack[slot.tos], repairing wrong-path overwrites.
- Undefined: checkpoints hold only {tos, count}; recovery restores pointers only. This saves NUM_TAGS*XLEN flops; a wrong-path push can corrupt the restored top.

Decomposition:
- frontend_types gets:
  - struct ras_ckpt_t {tos, count, top}, with the top field conditional on the macro;
  - localparam RAS_DEPTH=8.
- backend_types supplies COB_DEPTH and COB_ADDR_WIDTH.
- Sub-module ras_ckpt_file: NUM_TAGS-entry register file of ras_ckpt_t. One write port, one combinational read port, sync reset.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> count=3, pop_addr=0x300. Pop -> pop_valid=1, pop_addr=0x300, next cycle pop_addr=0x200.
- DEPTH=8, push 0x10..0x90 (9 pushes) -> count=8, top=0x90. 8 pops return 0x90..0x20. 9th pop -> pop_valid=0, count stays 0.
- Push 0xA0 with ckpt_en tag 3. Then wrong-path pop, pop, push 0xDEAD. Then recover tag 3 -> count=1, pop_addr=0xA0. Without the macro, pop_addr=0xDEAD.
- push_en & pop_en with top=0x40, count=2 -> pop_addr=0x40 and pop_valid=1 that cycle. Next cycle top=0x50 (the pushed value), count=2.
- recover_en and push_en and ckpt_en in the same cycle -> push and checkpoint ignored, slot restored. flush with recover_en -> count=0.
- rst asserted mid-sequence with count=5 -> next cycle count=0, empty=1, pop_addr=0, and recover of any tag yields count=0.
